// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit beside the EX-stage ALU.
// The full-precision result is computed when a request is accepted and held in
// pending registers; HI/LO are only written when the BUSY countdown expires,
// so the pipeline observes a fixed, parameterised latency per operation class.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDU_SEL,
  input  logic        START,
  output logic        BUSY,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  localparam logic [15:0] MULT_LOAD = 16'(MULT_CYCLES);
  localparam logic [15:0] DIV_LOAD  = 16'(DIV_CYCLES);

  logic [0:0]  state_reg;
  logic [15:0] count_reg;
  logic [63:0] pend_reg;       // {hi, lo} to commit on completion
  logic        pend_write_reg; // cleared for divide-by-zero: HI/LO keep old values
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic signed [63:0] mul_s;
  logic [63:0]        mul_u;
  logic               div_signed;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        dividend;
  logic [31:0]        divisor;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic [31:0]        quotient;
  logic [31:0]        remainder;

  // Combinational result datapath, sampled only on the accept edge.
  // Signed divide works on magnitudes and fixes signs afterwards so the
  // 0x80000000 / -1 case wraps to 0x80000000 without relying on tool behaviour.
  always_comb begin
    mul_s      = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    mul_u      = {32'd0, A} * {32'd0, B};
    div_signed = (MDU_SEL == OP_DIV);
    a_mag      = A[31] ? (~A + 32'd1) : A;
    b_mag      = B[31] ? (~B + 32'd1) : B;
    dividend   = div_signed ? a_mag : A;
    divisor    = div_signed ? b_mag : B;
    if (divisor == 32'd0) begin
      divisor = 32'd1;  // result discarded anyway; avoids X from a zero divide
    end
    q_u        = dividend / divisor;
    r_u        = dividend % divisor;
    quotient   = q_u;
    remainder  = r_u;
    if (div_signed) begin
      if (A[31] ^ B[31]) quotient = ~q_u + 32'd1;
      if (A[31])         remainder = ~r_u + 32'd1;
    end
  end

  // Control FSM, countdown, pending result and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= 16'd0;
      pend_reg       <= 64'd0;
      pend_write_reg <= 1'b0;
      hi_reg         <= 32'd0;
      lo_reg         <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (START) begin
            case (MDU_SEL)
              OP_MULT, OP_MULTU: begin
                pend_reg       <= (MDU_SEL == OP_MULT) ? mul_s : mul_u;
                pend_write_reg <= 1'b1;
                count_reg      <= MULT_LOAD;
                state_reg      <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_reg       <= {remainder, quotient};
                pend_write_reg <= (B != 32'd0);
                count_reg      <= DIV_LOAD;
                state_reg      <= RUN;
              end
              OP_MTHI: hi_reg <= A;
              OP_MTLO: lo_reg <= A;
              default: ;
            endcase
          end
        end
        default: begin
          // RUN: any START here is ignored by construction
          if (count_reg == 16'd1) begin
            if (pend_write_reg) begin
              hi_reg <= pend_reg[63:32];
              lo_reg <= pend_reg[31:0];
            end
            count_reg <= 16'd0;
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg - 16'd1;
          end
        end
      endcase
    end
  end

  assign BUSY = (state_reg == RUN);
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule
